// File: rtl/gif_frame_sequencer.sv
// Read sequencer for the 4-frame GIF pixel ROM with a 2-entry valid/ready output buffer.
// Optional feature: define GIF_PINGPONG_EN for a bouncing frame order instead of wrapping.
module gif_frame_sequencer #(
    parameter int SIZE_FRAME = 2047,
    parameter int WIDTH      = 11,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_SCANS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] mem_address,
    output logic [1:0]       mem_frame_sel,
    output logic             mem_rd,
    input  logic [23:0]      mem_rdata,
    output logic [23:0]      pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_first,
    output logic             pix_last,
    output logic [1:0]       frame_idx
);

    localparam int SCW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;
    localparam logic [WIDTH-1:0] LAST_ADDR  = WIDTH'(SIZE_FRAME);
    localparam logic [1:0]       LAST_FRAME = 2'(NUM_FRAMES - 1);
    localparam logic [SCW-1:0]   LAST_SCAN  = SCW'(HOLD_SCANS - 1);

    // Handshake: a pixel transfers on a rising edge where pix_valid & pix_ready;
    // pix_valid never drops and the head entry never changes until that transfer.

    logic [WIDTH-1:0] addr_q, addr_d;
    logic [1:0]       frame_q, frame_d;
    logic [SCW-1:0]   scan_q, scan_d;
`ifdef GIF_PINGPONG_EN
    logic             dir_q, dir_d;
`endif

    logic             inflight_q;
    logic             rt_first_q, rt_last_q;
    logic [1:0]       rt_frame_q;

    // FIFO entry layout: {data[23:0], first, last, frame[1:0]}
    logic [27:0]      head_q, head_d;
    logic [27:0]      tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [27:0]      new_entry;

    logic             pop;
    logic             push;
    logic             issue;
    logic [2:0]       occ;

    assign pop       = pix_valid & pix_ready;
    assign push      = inflight_q;
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q};
    // Reset gates the strobe so nothing is issued while rst is held.
    assign issue     = ~rst & enable & (occ < (3'd2 + {2'b00, pop}));
    assign new_entry = {mem_rdata, rt_first_q, rt_last_q, rt_frame_q};

    assign mem_rd        = issue;
    assign mem_address   = addr_q;
    assign mem_frame_sel = frame_q;

    assign pix_valid = (count_q != 2'd0);
    assign pix_data  = head_q[27:4];
    assign pix_first = head_q[3];
    assign pix_last  = head_q[2];
    assign frame_idx = head_q[1:0];

    always_comb begin
        addr_d  = addr_q;
        frame_d = frame_q;
        scan_d  = scan_q;
`ifdef GIF_PINGPONG_EN
        dir_d   = dir_q;
`endif
        if (issue) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
                if (scan_q == LAST_SCAN) begin
                    scan_d = '0;
`ifdef GIF_PINGPONG_EN
                    if (NUM_FRAMES > 1) begin
                        if (!dir_q) begin
                            if (frame_q == LAST_FRAME) begin
                                frame_d = frame_q - 2'd1;
                                dir_d   = 1'b1;
                            end else begin
                                frame_d = frame_q + 2'd1;
                            end
                        end else begin
                            if (frame_q == 2'd0) begin
                                frame_d = 2'd1;
                                dir_d   = 1'b0;
                            end else begin
                                frame_d = frame_q - 2'd1;
                            end
                        end
                    end
`else
                    frame_d = (frame_q == LAST_FRAME) ? 2'd0 : frame_q + 2'd1;
`endif
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Issue rule keeps push-without-pop away from a full buffer.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = new_entry;
                else                 tail_d = new_entry;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = new_entry;
                end else begin
                    head_d = tail_q;
                    tail_d = new_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            frame_q    <= '0;
            scan_q     <= '0;
`ifdef GIF_PINGPONG_EN
            dir_q      <= 1'b0;
`endif
            inflight_q <= 1'b0;
            rt_first_q <= 1'b0;
            rt_last_q  <= 1'b0;
            rt_frame_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            frame_q    <= frame_d;
            scan_q     <= scan_d;
`ifdef GIF_PINGPONG_EN
            dir_q      <= dir_d;
`endif
            inflight_q <= issue;
            if (issue) begin
                rt_first_q <= (addr_q == '0);
                rt_last_q  <= (addr_q == LAST_ADDR);
                rt_frame_q <= frame_q;
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_gif_frame_sequencer.sv
// Bench for gif_frame_sequencer: ROM model, directed phases, queue scoreboard checked by a monitor.
// Expected frame order follows GIF_PINGPONG_EN when the bench is built with it.
module tb_gif_frame_sequencer;

    localparam int W = 28;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] mem_address;
    logic [1:0]  mem_frame_sel;
    logic        mem_rd;
    logic [23:0] mem_rdata = 24'd0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_first;
    logic        pix_last;
    logic [1:0]  frame_idx;

    int total = 0;
    int bad = 0;
    int accepted = 0;
    int issued = 0;

    logic [W-1:0] exp_q[$];

    gif_frame_sequencer #(
        .SIZE_FRAME(7),
        .WIDTH(11),
        .NUM_FRAMES(3),
        .HOLD_SCANS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mem_address(mem_address),
        .mem_frame_sel(mem_frame_sel),
        .mem_rd(mem_rd),
        .mem_rdata(mem_rdata),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_first(pix_first),
        .pix_last(pix_last),
        .frame_idx(frame_idx)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    function automatic logic [23:0] pix_word(input logic [1:0] fr, input logic [10:0] a);
        return {4'hC, 2'b00, fr, 5'd0, a};
    endfunction

    // ROM model: 1-cycle latency, forced 0 when not read
    always @(posedge clk) mem_rdata <= mem_rd ? pix_word(mem_frame_sel, mem_address) : 24'd0;

    function automatic logic [42:0] all_outs();
        return {mem_address, mem_frame_sel, mem_rd, pix_data, pix_valid, pix_first, pix_last, frame_idx};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // 16 scans of 8 pixels; NUM_FRAMES=3, HOLD_SCANS=2
    task automatic fill_expected();
        int ftab[16];
`ifdef GIF_PINGPONG_EN
        ftab = '{0, 0, 1, 1, 2, 2, 1, 1, 0, 0, 1, 1, 2, 2, 1, 1};
`else
        ftab = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0, 0, 1, 1};
`endif
        exp_q.delete();
        for (int s = 0; s < 16; s++) begin
            for (int a = 0; a < 8; a++) begin
                exp_q.push_back({pix_word(2'(ftab[s]), 11'(a)), (a == 0), (a == 7), 2'(ftab[s])});
            end
        end
    endtask

    // Scoreboard monitor
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_head = '0;

    always @(negedge clk) begin
        logic [W-1:0] head;
        int occ;
        head = {pix_data, pix_first, pix_last, frame_idx};
        if (rst) begin
            issued = 0;
            accepted = 0;
            prev_stall = 1'b0;
        end else begin
            occ = issued - accepted;
            if (prev_stall) begin
                check("stall_valid", 64'(pix_valid), 64'd1);
                check("stall_stable", 64'(head), 64'(prev_head));
            end
            if (mem_rd) begin
                check("issue_rule", 64'((occ - int'(pix_valid && pix_ready)) < 2), 64'd1);
                issued++;
            end
            if (!enable) check("rd_while_disabled", 64'(mem_rd), 64'd0);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pix_underflow: got %h want none", head);
                end else begin
                    check("pixel", 64'(head), 64'(exp_q.pop_front()));
                end
                accepted++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_head = head;
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accepted(input int target, input int budget, input string name);
        int n = 0;
        while (accepted < target && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(accepted >= target), 64'd1);
    endtask

    initial begin
        logic [3:0] pat;
        int a0;
        int n;
        pat = 4'b1001;
        rst = 1'b1;
        enable = 1'b0;
        pix_ready = 1'b1;
        fill_expected();
        repeat (3) step();
        check("reset_outputs", 64'(all_outs()), 64'd0);
        rst = 1'b0;
        step();

        // Start-up latency: pix_valid appears two cycles after enable
        enable = 1'b1;
        @(negedge clk);
        check("lat_c0_rd", 64'(mem_rd), 64'd1);
        check("lat_c0_valid", 64'(pix_valid), 64'd0);
        @(negedge clk);
        check("lat_c1_valid", 64'(pix_valid), 64'd0);
        @(negedge clk);
        check("lat_c2_valid", 64'(pix_valid), 64'd1);
        wait_accepted(20, 100, "phase1_progress");

        // Backpressure 1,0,0,1
        for (int i = 0; i < 60; i++) begin
            pix_ready = pat[i % 4];
            step();
        end
        pix_ready = 1'b1;

        // Pause before address 5 is issued
        n = 0;
        while (mem_address != 11'd5 && n < 40) begin
            step();
            n++;
        end
        check("found_addr5", 64'(mem_address), 64'd5);
        enable = 1'b0;
        a0 = accepted;
        repeat (6) step();
        check("drain_at_most_2", 64'((accepted - a0) <= 2), 64'd1);
        check("paused_valid", 64'(pix_valid), 64'd0);
        check("paused_addr_held", 64'(mem_address), 64'd5);
        enable = 1'b1;
        wait_accepted(90, 300, "resume_progress");

        // Fill the buffer, then reset asynchronously mid-scan
        pix_ready = 1'b0;
        repeat (4) step();
        check("full_valid", 64'(pix_valid), 64'd1);
        check("full_no_rd", 64'(mem_rd), 64'd0);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'(all_outs()), 64'd0);
        fill_expected();
        repeat (2) step();
        rst = 1'b0;
        pix_ready = 1'b1;
        wait_accepted(20, 100, "post_reset_progress");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
